// File: rtl/decode_stage_pipe.sv
// ID stage: opcode decode into a registered ID/EX slot with valid/ready flow control,
// load-use stall bubbles, branch flush and a saturating illegal-opcode counter.
module decode_stage_pipe #(
  parameter int HAZARD_EN = 1,
  parameter int STALL_CYC = 1,
  parameter int ERR_CNT_W = 8,
  parameter int LINK_REG  = 31
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          instr_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  input  logic                 ex_memread_i,
  input  logic [4:0]           ex_rt_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [14:0]          ctrl_o,
  output logic [4:0]           wr_addr_o,
  output logic                 illegal_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_e;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_BLE = 6'b000111;
  localparam logic [5:0] OP_BLT = 6'b000110;
  localparam logic [5:0] OP_LI  = 6'b001111;
  localparam logic [5:0] OP_ORI = 6'b001101;

  // The hazard cycle itself issues the first bubble, so STALL covers the remaining ones.
  localparam logic       STALL_MULTI = (STALL_CYC > 1);
  localparam logic [1:0] STALL_LOAD  = (STALL_CYC > 1) ? 2'(STALL_CYC - 2) : 2'd0;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  // Returns {illegal, ctrl[14:0]}.
  function automatic logic [15:0] decode_f(input logic [5:0] op);
    case (op)
      OP_R:    decode_f = {1'b0, 15'b1_010_0_01_0_1_0_0_00_00};
      OP_ADDI: decode_f = {1'b0, 15'b1_000_1_00_0_1_0_0_00_00};
      OP_J:    decode_f = {1'b0, 15'b0_011_0_00_0_0_0_0_00_00};
      OP_JAL:  decode_f = {1'b0, 15'b1_100_0_10_0_0_0_0_11_00};
      OP_LW:   decode_f = {1'b0, 15'b1_000_1_00_0_1_1_0_01_00};
      OP_SW:   decode_f = {1'b0, 15'b0_000_1_00_0_1_0_1_00_00};
      OP_BEQ:  decode_f = {1'b0, 15'b0_011_0_00_1_1_0_0_00_00};
      OP_BNE:  decode_f = {1'b0, 15'b0_001_0_00_1_1_0_0_00_11};
      OP_BLE:  decode_f = {1'b0, 15'b0_110_0_00_1_1_0_0_00_01};
      OP_BLT:  decode_f = {1'b0, 15'b0_111_0_00_1_1_0_0_00_10};
      OP_LI:   decode_f = {1'b0, 15'b1_111_1_00_0_1_0_0_10_00};
      OP_ORI:  decode_f = {1'b0, 15'b1_110_1_00_0_1_0_0_00_00};
      default: decode_f = {1'b1, 15'b0};
    endcase
  endfunction

  // Opcodes that read rt as a source operand.
  function automatic logic reads_rt_f(input logic [5:0] op);
    case (op)
      OP_R, OP_SW, OP_BEQ, OP_BNE, OP_BLE, OP_BLT: reads_rt_f = 1'b1;
      default:                                     reads_rt_f = 1'b0;
    endcase
  endfunction

  state_e                 state_q, state_d;
  logic [1:0]             stall_cnt_q, stall_cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [14:0]            ctrl_q, ctrl_d;
  logic [4:0]             wr_addr_q, wr_addr_d;
  logic                   illegal_q, illegal_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [5:0]  op_s;
  logic [4:0]  rs_s, rt_s, rd_s;
  logic [15:0] dec_s;
  logic [4:0]  dec_wr_s;
  logic        hazard_s, advance_s, in_ready_s, load_s, kill_s;
  logic        unused_s;

  assign op_s     = instr_i[31:26];
  assign rs_s     = instr_i[25:21];
  assign rt_s     = instr_i[20:16];
  assign rd_s     = instr_i[15:11];
  assign unused_s = ^instr_i[10:0];

  // Decode, handshake, hazard detection and next-state computation.
  always_comb begin
    dec_s = decode_f(op_s);
    case (dec_s[9:8])
      2'b00:   dec_wr_s = rt_s;
      2'b01:   dec_wr_s = rd_s;
      2'b10:   dec_wr_s = 5'(LINK_REG);
      default: dec_wr_s = 5'd0;
    endcase

    hazard_s = (HAZARD_EN != 0) && (state_q == ST_RUN) && in_valid_i && ex_memread_i &&
               (ex_rt_i != 5'd0) &&
               ((ex_rt_i == rs_s) || ((ex_rt_i == rt_s) && reads_rt_f(op_s)));
    advance_s  = !out_valid_q || out_ready_i;
    in_ready_s = (state_q == ST_RUN) && !flush_i && !hazard_s && advance_s;

    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    load_s      = 1'b0;
    kill_s      = 1'b0;

    if (flush_i) begin
      kill_s      = 1'b1;
      state_d     = ST_RUN;
      stall_cnt_d = 2'd0;
    end else if (state_q == ST_RUN) begin
      if (in_valid_i && in_ready_s) begin
        load_s = 1'b1;
      end else if (hazard_s && advance_s) begin
        kill_s = 1'b1;
        if (STALL_MULTI) begin
          state_d     = ST_STALL;
          stall_cnt_d = STALL_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end else if (advance_s) begin
        kill_s = 1'b1;
      end else begin
        kill_s = 1'b0;
      end
    end else begin
      if (advance_s) begin
        kill_s = 1'b1;
        if (stall_cnt_q == 2'd0) begin
          state_d = ST_RUN;
        end else begin
          stall_cnt_d = stall_cnt_q - 2'd1;
        end
      end else begin
        kill_s = 1'b0;
      end
    end

    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    wr_addr_d   = wr_addr_q;
    illegal_d   = illegal_q;
    err_cnt_d   = err_cnt_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec_s[14:0];
      wr_addr_d   = dec_s[15] ? 5'd0 : dec_wr_s;
      illegal_d   = dec_s[15];
      if (dec_s[15] && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else if (kill_s) begin
      out_valid_d = 1'b0;
      ctrl_d      = 15'd0;
      wr_addr_d   = 5'd0;
      illegal_d   = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Slot, FSM and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 2'd0;
      out_valid_q <= 1'b0;
      ctrl_q      <= 15'd0;
      wr_addr_q   <= 5'd0;
      illegal_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      wr_addr_q   <= wr_addr_d;
      illegal_q   <= illegal_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_q;
  assign ctrl_o      = ctrl_q;
  assign wr_addr_o   = wr_addr_q;
  assign illegal_o   = illegal_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
